// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave).
interface mem_stage_if #(
  parameter int XLEN = 64,
  parameter int PAW  = 64
);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_we;
  logic [PAW-1:0]  dmem_req_addr;
  logic [XLEN-1:0] dmem_req_wdata;
  logic [7:0]      dmem_req_wmask;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_data;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wmask,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wmask,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-stage load/store unit: issues one data-memory access per EX/MEM slot,
// stalls the pipeline until it completes, and drives the mem-stage bypass.
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int PAW    = 64,
  parameter int LREG_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipeval,
  input  logic [LREG_W-1:0] rd,
  input  logic              need_to_wb,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_unsigned,
  input  logic [3:0]        ls_size,
  input  logic [PAW-1:0]    ls_address,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   ex_result,
  mem_stage_if.master       dmem,
  output logic              mem_stall,
  output logic              misalign,
  output logic [LREG_W-1:0] mem_byp_rd,
  output logic              mem_byp_need_to_wb,
  output logic [XLEN-1:0]   mem_byp_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Anything that is not a clean one-hot size is handled as a dword access.
  function automatic logic [1:0] size_code(input logic [3:0] s);
    case (s)
      4'b0001: size_code = SZ_B;
      4'b0010: size_code = SZ_H;
      4'b0100: size_code = SZ_W;
      default: size_code = SZ_D;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] data,
                                                   input logic [2:0]      off,
                                                   input logic [1:0]      sz,
                                                   input logic            uns);
    logic [XLEN-1:0] s;
    s = data >> {off, 3'b000};
    case (sz)
      SZ_B:    extract_load = {{(XLEN-8){~uns & s[7]}}, s[7:0]};
      SZ_H:    extract_load = {{(XLEN-16){~uns & s[15]}}, s[15:0]};
      SZ_W:    extract_load = {{(XLEN-32){~uns & s[31]}}, s[31:0]};
      default: extract_load = s;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;

  logic [1:0] sz;
  logic [2:0] off;
  logic       mem_instr;
  logic       unaligned;
  logic       mem_op;

  always_comb begin
    sz        = size_code(ls_size);
    off       = ls_address[2:0];
    mem_instr = pipeval & (is_load | is_store);
    case (sz)
      SZ_B:    unaligned = 1'b0;
      SZ_H:    unaligned = off[0];
      SZ_W:    unaligned = |off[1:0];
      default: unaligned = |off;
    endcase
    misalign = mem_instr & unaligned;
    mem_op   = mem_instr & ~unaligned;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
    end
  end

  // A response is only consumed in RESP; elsewhere dmem_resp_valid is ignored.
  always_comb begin
    state_d   = state_q;
    ld_data_d = ld_data_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d = dmem.dmem_req_ready ? RESP : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem.dmem_req_ready) begin
          state_d = RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (dmem.dmem_resp_valid) begin
          state_d = DONE;
          if (is_load) begin
            ld_data_d = extract_load(dmem.dmem_resp_data, off, sz, is_unsigned);
          end else begin
            ld_data_d = ld_data_q;
          end
        end else begin
          state_d = RESP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem.dmem_req_valid = 1'b0;
    mem_stall           = 1'b0;
    mem_byp_need_to_wb  = 1'b0;
    mem_byp_result      = ex_result;
    mem_byp_rd          = rd;
    dmem.dmem_req_we    = is_store;
    dmem.dmem_req_addr  = {ls_address[PAW-1:3], 3'b000};
    if (is_store) begin
      dmem.dmem_req_wdata = store_data << {off, 3'b000};
      dmem.dmem_req_wmask = size_mask(sz) << off;
    end else begin
      dmem.dmem_req_wdata = '0;
      dmem.dmem_req_wmask = 8'h00;
    end
    case (state_q)
      IDLE: begin
        dmem.dmem_req_valid = mem_op;
        mem_stall           = mem_op;
        mem_byp_need_to_wb  = pipeval & need_to_wb & ~(is_load | is_store);
      end
      REQ: begin
        dmem.dmem_req_valid = 1'b1;
        mem_stall           = 1'b1;
      end
      RESP: begin
        mem_stall = 1'b1;
      end
      DONE: begin
        if (is_load) begin
          mem_byp_need_to_wb = pipeval & need_to_wb;
          mem_byp_result     = ld_data_q;
        end else begin
          mem_byp_need_to_wb = 1'b0;
        end
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

endmodule
